// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver data width and pointer width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  // Width of one received character, shared by the receiver and its buffers.
  localparam int UART_DATA_W = 8;

  // Circular-buffer pointer width: index bits plus one wrap bit.
  // The wrap bit is what tells a full buffer from an empty one.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Write strike and FWFT read stream between the UART receiver, the buffer and the host.
// Latency: wires only.
// Backpressure: none on the write side; rd_ready throttles the read side.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W
);

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  // Environment side: the receiver strikes bytes in and the host consumes them.
  modport master (
    output wr_data, wr_valid, rd_ready,
    input  rd_data, rd_valid
  );

  // Buffer side.
  modport slave (
    input  wr_data, wr_valid, rd_ready,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage for the receive buffer; synchronous write, asynchronous read.
// Latency: a write is visible on the read port right after the writing edge.
// Backpressure: none; the caller decides when to write.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array is not reset; the top-level masks rd_data while the buffer is empty.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer: captures receiver bytes, presents them FWFT, tracks drops and drives rts_n.
// Latency: a byte written into an empty buffer is on rd_data in the next cycle.
// Backpressure: the receiver cannot be stalled, so writes into a full buffer are dropped and counted.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W       = UART_DATA_W,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_rx_fifo_if.slave          bus,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic [7:0]             ovf_count,
  input  logic                   clr_ovf,
  output logic                   rts_n
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
  localparam logic [PW-1:0] THRESH_L = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] ONE_L    = PW'(1);

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     level_q;
  logic [PW-1:0]     level_nxt;
  logic              empty_q;
  logic              full_q;
  logic              rts_q;
  logic              ovf_q;
  logic [7:0]        ovf_cnt_q;
  logic              push;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] mem_rdata;

  // Flush overrides everything; a full buffer still accepts a byte when the head leaves in the same cycle.
  assign pop  = !empty_q && bus.rd_ready && !flush;
  assign push = bus.wr_valid && (!full_q || pop) && !flush;
  assign drop = bus.wr_valid && full_q && !pop && !flush;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (mem_rdata)
  );

  // Next occupancy, shared by the level counter, the flags and rts_n.
  always_comb begin
    level_nxt = level_q;
    if (flush) begin
      level_nxt = '0;
    end else if (push && !pop) begin
      level_nxt = level_q + ONE_L;
    end else if (pop && !push) begin
      level_nxt = level_q - ONE_L;
    end
  end

  // Read/write pointers; index bits wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_L;
      if (pop)  rd_ptr <= rd_ptr + ONE_L;
    end
  end

  // Registered occupancy, flags and far-end flow control, all taken from the same next level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      rts_q   <= 1'b0;
    end else begin
      level_q <= level_nxt;
      empty_q <= (level_nxt == '0);
      full_q  <= (level_nxt == DEPTH_L);
      rts_q   <= (level_nxt >= THRESH_L);
    end
  end

  // Drop accounting; a drop in the same cycle as a clear leaves exactly one counted drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (clr_ovf) begin
        ovf_cnt_q <= 8'd1;
      end else if (ovf_cnt_q != 8'hFF) begin
        ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
    end else if (clr_ovf) begin
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end
  end

  // Stale memory contents are hidden while empty so rd_data reads zero with no head.
  assign bus.rd_valid = !empty_q;
  assign bus.rd_data  = empty_q ? '0 : mem_rdata;

  assign level     = level_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = ovf_q;
  assign ovf_count = ovf_cnt_q;
  assign rts_n     = rts_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with hand-computed expectations.
// Latency: checks are sampled 1 time unit after each rising edge.
// Backpressure: exercises overflow drops, full push/pop and host stalls.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       clr_ovf;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       overflow;
  logic [7:0] ovf_count;
  logic       rts_n;

  int n_total;
  int n_pass;

  uart_rx_fifo_if #(.DATA_W(8)) bus ();

  uart_rx_fifo #(
    .DATA_W       (8),
    .DEPTH        (16),
    .AFULL_THRESH (12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .flush     (flush),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .ovf_count (ovf_count),
    .clr_ovf   (clr_ovf),
    .rts_n     (rts_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_valid"},  32'(bus.rd_valid), 32'd0);
    chk({tag, "_rd_data"},   32'(bus.rd_data),  32'd0);
    chk({tag, "_level"},     32'(level),        32'd0);
    chk({tag, "_empty"},     32'(empty),        32'd1);
    chk({tag, "_full"},      32'(full),         32'd0);
    chk({tag, "_overflow"},  32'(overflow),     32'd0);
    chk({tag, "_ovf_count"}, 32'(ovf_count),    32'd0);
    chk({tag, "_rts_n"},     32'(rts_n),        32'd0);
  endtask

  // Fill all 16 entries with base, base+1, ... with no pop.
  task automatic fill16(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      bus.wr_data  = base + 8'(i);
      bus.wr_valid = 1'b1;
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total      = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    clr_ovf      = 1'b0;
    bus.wr_data  = '0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;

    // Reset values.
    repeat (3) tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Single write then pop.
    bus.wr_data  = 8'hA5;
    bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    chk("one_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("one_rd_data",  32'(bus.rd_data),  32'hA5);
    chk("one_level",    32'(level),        32'd1);
    chk("one_empty",    32'(empty),        32'd0);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("one_pop_level", 32'(level),        32'd0);
    chk("one_pop_empty", 32'(empty),        32'd1);
    chk("one_pop_valid", 32'(bus.rd_valid), 32'd0);

    // Fill 0x00..0x0F, rts_n rises exactly after the 12th write.
    for (int i = 0; i < 16; i++) begin
      bus.wr_data  = 8'(i);
      bus.wr_valid = 1'b1;
      tick();
      chk("fill_rts_n", 32'(rts_n), 32'((i + 1) >= 12));
    end
    bus.wr_valid = 1'b0;
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_level", 32'(level), 32'd16);

    // Three drops while full.
    bus.wr_data  = 8'hEE;
    bus.wr_valid = 1'b1;
    repeat (3) tick();
    bus.wr_valid = 1'b0;
    chk("drop3_overflow", 32'(overflow),    32'd1);
    chk("drop3_count",    32'(ovf_count),   32'd3);
    chk("drop3_level",    32'(level),       32'd16);
    chk("drop3_head",     32'(bus.rd_data), 32'h00);

    // 257 more drops: 260 total saturates at 255.
    bus.wr_valid = 1'b1;
    repeat (257) tick();
    bus.wr_valid = 1'b0;
    chk("drop260_count",    32'(ovf_count), 32'd255);
    chk("drop260_overflow", 32'(overflow),  32'd1);

    // Drain in order; contents untouched by the drops.
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 32'(bus.rd_valid), 32'd1);
      chk("drain_data",  32'(bus.rd_data),  32'(i));
      tick();
      chk("drain_level", 32'(level), 32'(15 - i));
      chk("drain_rts_n", 32'(rts_n), 32'((15 - i) >= 12));
    end
    bus.rd_ready = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);

    // Plain clear.
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_overflow", 32'(overflow),  32'd0);
    chk("clr_count",    32'(ovf_count), 32'd0);

    // Full: simultaneous push and pop keeps level at 16, new byte goes last.
    fill16(8'h20);
    bus.wr_data  = 8'h99;
    bus.wr_valid = 1'b1;
    bus.rd_ready = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    chk("fullpp_level", 32'(level),       32'd16);
    chk("fullpp_full",  32'(full),        32'd1);
    chk("fullpp_nodrop", 32'(ovf_count),  32'd0);
    chk("fullpp_head",  32'(bus.rd_data), 32'h21);
    for (int i = 0; i < 16; i++) begin
      chk("fullpp_drain", 32'(bus.rd_data), (i < 15) ? 32'(8'h21 + 8'(i)) : 32'h99);
      tick();
    end
    chk("fullpp_empty", 32'(empty), 32'd1);

    // Empty: write with rd_ready high is stored, not lost.
    bus.wr_data  = 8'h77;
    bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    chk("emptyw_level", 32'(level),        32'd1);
    chk("emptyw_valid", 32'(bus.rd_valid), 32'd1);
    chk("emptyw_data",  32'(bus.rd_data),  32'h77);
    tick();
    bus.rd_ready = 1'b0;
    chk("emptyw_pop_level", 32'(level), 32'd0);

    // Clear with a simultaneous drop: the drop wins.
    fill16(8'h40);
    chk("clrdrop_rts_n", 32'(rts_n), 32'd1);
    bus.wr_data  = 8'hF0;
    bus.wr_valid = 1'b1;
    clr_ovf      = 1'b1;
    tick();
    clr_ovf      = 1'b0;
    chk("clrdrop_overflow", 32'(overflow),  32'd1);
    chk("clrdrop_count",    32'(ovf_count), 32'd1);

    // Flush with a simultaneous write: emptied, no drop counted.
    flush = 1'b1;
    tick();
    flush        = 1'b0;
    bus.wr_valid = 1'b0;
    chk("flush_level",    32'(level),        32'd0);
    chk("flush_empty",    32'(empty),        32'd1);
    chk("flush_valid",    32'(bus.rd_valid), 32'd0);
    chk("flush_rd_data",  32'(bus.rd_data),  32'd0);
    chk("flush_count",    32'(ovf_count),    32'd1);
    chk("flush_overflow", 32'(overflow),     32'd1);
    chk("flush_rts_n",    32'(rts_n),        32'd0);
    tick();
    chk("flush_hold_level", 32'(level), 32'd0);

    // Asynchronous reset mid-transfer with seven entries stored.
    for (int i = 0; i < 7; i++) begin
      bus.wr_data  = 8'h50 + 8'(i);
      bus.wr_valid = 1'b1;
      tick();
    end
    chk("pre_arst_level", 32'(level), 32'd7);
    bus.wr_data  = 8'h57;
    bus.rd_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk_reset_vals("post_arst");

    // After release a single byte reads back alone.
    bus.wr_data  = 8'h3C;
    bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    chk("post_wr_valid", 32'(bus.rd_valid), 32'd1);
    chk("post_wr_data",  32'(bus.rd_data),  32'h3C);
    chk("post_wr_level", 32'(level),        32'd1);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("post_pop_valid", 32'(bus.rd_valid), 32'd0);
    chk("post_pop_level", 32'(level),        32'd0);
    chk("post_pop_empty", 32'(empty),        32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the UART receiver and the host-side consumer. Captures each single-cycle received byte, holds up to DEPTH entries, and presents them on a first-word-fall-through valid/ready stream. The receiver has no backpressure, so the block tracks overflow and drives an RTS-style flow-control output toward the far-end transmitter.

## Interface
- DATA_W, 8, width of a stored word (receiver data width).
- DEPTH, 16, number of entries; power of two, ≥ 2.
- AFULL_THRESH, 12, level at or above which rts_n is deasserted (driven high); must satisfy 1 ≤ AFULL_THRESH ≤ DEPTH.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_data  in  DATA_W  received byte; qualified by wr_valid.
- wr_valid  in  1  one-cycle write strike from the receiver; no ready is returned.
- flush  in  1  synchronous empty of all entries.
- rd_data  out  DATA_W  head entry; stable while rd_valid && !rd_ready.
- rd_valid  out  1  head entry present.
- rd_ready  in  1  consumer accepts the head entry when rd_valid is also high.
- level  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky: at least one byte dropped since the last clear.
- ovf_count  out  8  dropped-byte count, saturates at 255.
- clr_ovf  in  1  clears overflow and ovf_count.
- rts_n  out  1  low = ok to send; high = level ≥ AFULL_THRESH.

## Operation
- Storage: circular buffer, write and read pointers of $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty. Pointers wrap from DEPTH-1 to 0 in the index bits.
- Push: wr_valid && (!full || pop) && !flush. Pop: rd_valid && rd_ready && !flush.
- When full, a simultaneous push and pop both occur and level stays DEPTH; the pushed byte lands in the freed slot.
- When empty, a push with rd_ready high does not pop; the byte is stored and becomes the head.
- Drop: wr_valid && full && !pop && !flush. The byte is discarded, overflow ← 1, and ovf_count increments, saturating at 255.
- clr_ovf: overflow ← 0, ovf_count ← 0. If a drop occurs in the same cycle, the drop wins: overflow = 1, ovf_count = 1.
- flush: both pointers ← 0, so level = 0 and rd_valid = 0 next cycle. A write in the same cycle is discarded and is not counted as a drop. flush does not touch overflow or ovf_count.
- rts_n: registered, equal to (level_next ≥ AFULL_THRESH).

## Timing
- Reset values: rd_valid 0, rd_data 0, level 0, empty 1, full 0, overflow 0, ovf_count 0, rts_n 0, pointers 0.
- Asynchronous reset mid-operation discards all contents immediately; there is no partial state after release.
- Write-to-read latency: a byte written at edge N into an empty FIFO gives rd_valid = 1 and rd_data = byte after edge N, i.e. visible in cycle N+1.
- level, empty, full, overflow, ovf_count and rts_n are all registered and reflect the edge at which the event occurred.
- Sustained throughput: one push and one pop per cycle.
- rd_data changes only on a pop, a flush, or a write into an empty FIFO.

## Structure
- Shared package uart_pkg holds UART_DATA_W = 8 and a ptr_t width helper function (clog2-based). The receiver and this block both use UART_DATA_W.
- One sub-module, uart_fifo_mem: DEPTH × DATA_W storage with one synchronous write port and one asynchronous read port, indexed by the pointer LSBs.
- The top level holds the pointers, the level counter, the flags, overflow accounting and rts_n.

## Test plan
- Reset, then a single write of 0xA5 → rd_valid high the next cycle with rd_data = 0xA5, level = 1, empty = 0. Pop → level = 0, empty = 1.
- Write 16 bytes 0x00..0x0F with rd_ready = 0 → full = 1. rts_n goes high exactly after the 12th write. Drain → bytes read back in order and rts_n returns low when level < 12.
- When full, write 3 more bytes with no pop → overflow = 1, ovf_count = 3 and the contents are unchanged. Then 260 drops total → ovf_count = 255.
- When full, write and pop in the same cycle → level stays 16 and the new byte is read last. When empty, write with rd_ready = 1 → level = 1 and the byte is not lost.
- clr_ovf with a simultaneous drop → overflow = 1, ovf_count = 1. flush with a simultaneous write → level = 0, no drop counted, ovf_count unchanged.
- Assert rst_n low with level = 7 and a transfer in progress → all outputs take their reset values at once. After release, a write of 0x3C reads back alone.
